// File: rtl/mul_seq_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
// The MUL_SEQ_EARLY_EXIT_EN option lives in mul_seq.sv.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  localparam int DEF_WIDTH = 8;

  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/cond_neg.sv
// Conditional two's-complement negation: y = neg ? -x : x.
// Used for operand magnitudes and for re-applying the product sign.
module cond_neg #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/mul_seq.sv
// Sequential radix-2 shift-add multiplier, unsigned or signed per operation.
// Define MUL_SEQ_EARLY_EXIT_EN to stop once the remaining multiplier is zero.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t state, state_nx;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] res;
  logic [CW-1:0]      cnt;
  logic               neg_flag;
  logic               last;

  cond_neg #(.W(WIDTH)) u_neg_a (
    .x   (a),
    .neg (signed_mode & a[WIDTH-1]),
    .y   (a_mag)
  );

  cond_neg #(.W(WIDTH)) u_neg_b (
    .x   (b),
    .neg (signed_mode & b[WIDTH-1]),
    .y   (b_mag)
  );

  cond_neg #(.W(2*WIDTH)) u_neg_p (
    .x   (acc),
    .neg (neg_flag),
    .y   (res)
  );

`ifdef MUL_SEQ_EARLY_EXIT_EN
  // mplier[W-1:1] is what remains after this edge's shift
  assign last = (cnt == CNT_LAST) || (mplier[WIDTH-1:1] == '0);
`else
  assign last = (cnt == CNT_LAST);
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (last)  state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      neg_flag <= 1'b0;
      p        <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            acc      <= '0;
            mcand    <= {{WIDTH{1'b0}}, a_mag};
            mplier   <= b_mag;
            cnt      <= '0;
            neg_flag <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        CALC: begin
          acc    <= acc + (mplier[0] ? mcand : '0);
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
        end
        FIN: begin
          p    <= res;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq at WIDTH 4, 8 and 16.
// Products and latencies come from a plain-arithmetic reference model.
module tb_mul_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s4 = 0, m4 = 0, busy4, done4;
  logic [3:0]  a4 = 0, b4 = 0;
  logic [7:0]  p4;
  logic        s8 = 0, m8 = 0, busy8, done8;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] p8;
  logic        s16 = 0, m16 = 0, busy16, done16;
  logic [15:0] a16 = 0, b16 = 0;
  logic [31:0] p16;

  mul_seq #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4),
    .signed_mode(m4), .busy(busy4), .done(done4), .p(p4)
  );
  mul_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8),
    .signed_mode(m8), .busy(busy8), .done(done8), .p(p8)
  );
  mul_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(s16), .a(a16), .b(b16),
    .signed_mode(m16), .busy(busy16), .done(done16), .p(p16)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic longint sx(input int w, input logic [15:0] v);
    longint u;
    u = longint'(v) & ((longint'(1) << w) - 1);
    if (v[w-1]) return u - (longint'(1) << w);
    return u;
  endfunction

  function automatic logic [31:0] ref_p(input int w, input logic [15:0] av,
                                        input logic [15:0] bv, input logic sm);
    longint m, r;
    m = (longint'(1) << w) - 1;
    if (sm) r = sx(w, av) * sx(w, bv);
    else    r = (longint'(av) & m) * (longint'(bv) & m);
    return 32'(r & ((longint'(1) << (2 * w)) - 1));
  endfunction

  function automatic int ref_lat(input int w, input logic [15:0] bv,
                                 input logic sm);
`ifdef MUL_SEQ_EARLY_EXIT_EN
    longint mag;
    int k;
    mag = sx(w, bv);
    if (!sm) mag = longint'(bv) & ((longint'(1) << w) - 1);
    if (mag < 0) mag = -mag;
    k = 0;
    for (int i = 0; i < w; i++)
      if (mag[i]) k = i;
    return k + 2;
`else
    return w + 1;
`endif
  endfunction

  task automatic drive(input int w, input logic s, input logic [15:0] av,
                       input logic [15:0] bv, input logic sm);
    case (w)
      4:       begin s4 = s;  a4 = av[3:0];  b4 = bv[3:0];  m4 = sm;  end
      8:       begin s8 = s;  a8 = av[7:0];  b8 = bv[7:0];  m8 = sm;  end
      default: begin s16 = s; a16 = av;      b16 = bv;      m16 = sm; end
    endcase
  endtask

  function automatic logic done_of(input int w);
    return (w == 4) ? done4 : (w == 8) ? done8 : done16;
  endfunction

  function automatic logic busy_of(input int w);
    return (w == 4) ? busy4 : (w == 8) ? busy8 : busy16;
  endfunction

  function automatic logic [31:0] p_of(input int w);
    return (w == 4) ? 32'(p4) : (w == 8) ? 32'(p8) : p16;
  endfunction

  // Called #1 after an edge; returns edges from start edge to done.
  task automatic op(input int w, input logic [15:0] av, input logic [15:0] bv,
                    input logic sm, output logic [31:0] pr, output int lat);
    drive(w, 1'b1, av, bv, sm);
    @(posedge clk); #1;
    drive(w, 1'b0, ~av, ~bv, ~sm);
    chk("busy_after_e0", 64'(busy_of(w)), 64'd1);
    lat = -1;
    for (int n = 1; n <= w + 4; n++) begin
      @(posedge clk); #1;
      if (done_of(w)) begin
        lat = n;
        break;
      end
    end
    pr = p_of(w);
    if (lat > 0) chk("busy_at_done", 64'(busy_of(w)), 64'd0);
  endtask

  task automatic run_chk(input string nm, input int w, input logic [15:0] av,
                         input logic [15:0] bv, input logic sm);
    logic [31:0] pr;
    int lat;
    op(w, av, bv, sm, pr, lat);
    chk($sformatf("%s_p(a=%0h,b=%0h,s=%0d)", nm, av, bv, sm),
        64'(pr), 64'(ref_p(w, av, bv, sm)));
    chk($sformatf("%s_lat(b=%0h)", nm, bv), 64'(lat),
        64'(ref_lat(w, bv, sm)));
  endtask

  // Counts done pulses over a window of edges.
  task automatic count_done(input int w, input int edges, output int cnt);
    cnt = 0;
    for (int n = 0; n < edges; n++) begin
      @(posedge clk); #1;
      if (done_of(w)) cnt++;
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [15:0] p;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [31:0] pr;
    int lat, nd;

    tbl[0] = '{8'd200, 8'd150, 1'b0, 16'h7530};
    tbl[1] = '{8'hF9,  8'h05,  1'b1, 16'hFFDD};
    tbl[2] = '{8'h80,  8'h80,  1'b1, 16'h4000};
    tbl[3] = '{8'h7F,  8'h80,  1'b1, 16'hC080};
    tbl[4] = '{8'h00,  8'hF3,  1'b1, 16'h0000};
    tbl[5] = '{8'h55,  8'h00,  1'b0, 16'h0000};
    tbl[6] = '{8'h03,  8'h04,  1'b0, 16'h000C};
    tbl[7] = '{8'hFF,  8'h80,  1'b0, 16'h7F80};
    tbl[8] = '{8'hFF,  8'hFF,  1'b0, 16'hFE01};
    tbl[9] = '{8'hFF,  8'hFF,  1'b1, 16'h0001};

    #12;
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_p", 64'(p8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      op(8, 16'(tbl[i].a), 16'(tbl[i].b), tbl[i].sm, pr, lat);
      chk($sformatf("tbl%0d_p", i), 64'(pr), 64'(tbl[i].p));
      chk($sformatf("tbl%0d_lat", i), 64'(lat),
          64'(ref_lat(8, 16'(tbl[i].b), tbl[i].sm)));
    end

    // start re-pulsed at E3 is ignored
    drive(8, 1'b1, 16'd200, 16'd150, 1'b0);
    @(posedge clk); #1;
    drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    drive(8, 1'b1, 16'd3, 16'd3, 1'b1);
    @(posedge clk); #1;
    drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
    lat = -1;
    for (int n = 4; n <= 14; n++) begin
      @(posedge clk); #1;
      if (done8) begin
        lat = n;
        break;
      end
    end
    chk("repulse_p", 64'(p8), 64'd30000);
    chk("repulse_lat", 64'(lat), 64'(ref_lat(8, 16'd150, 1'b0)));
    count_done(8, 14, nd);
    chk("repulse_no_extra_done", 64'(nd), 64'd0);

    // start held high across done: back-to-back
    drive(8, 1'b1, 16'd10, 16'd20, 1'b0);
    @(posedge clk); #1;
    lat = -1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (done8) begin
        lat = n;
        break;
      end
    end
    chk("b2b_first_p", 64'(p8), 64'd200);
    chk("b2b_first_lat", 64'(lat), 64'(ref_lat(8, 16'd20, 1'b0)));
    drive(8, 1'b1, 16'd7, 16'd9, 1'b0);
    @(posedge clk); #1;
    drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
    chk("b2b_second_busy", 64'(busy8), 64'd1);
    lat = -1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (done8) begin
        lat = n;
        break;
      end
    end
    chk("b2b_second_p", 64'(p8), 64'd63);
    chk("b2b_second_lat", 64'(lat), 64'(ref_lat(8, 16'd9, 1'b0)));

    // asynchronous reset mid-CALC
    drive(8, 1'b1, 16'd100, 16'd255, 1'b0);
    @(posedge clk); #1;
    drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy8), 64'd0);
    chk("midrst_done", 64'(done8), 64'd0);
    chk("midrst_p", 64'(p8), 64'd0);
    #1;
    rst_n = 1'b1;
    count_done(8, 14, nd);
    chk("midrst_no_done", 64'(nd), 64'd0);
    run_chk("post_rst", 8, 16'd13, 16'd11, 1'b0);

    for (int i = 0; i < 200; i++)
      run_chk("rnd8", 8, 16'($urandom_range(0, 255)),
              16'($urandom_range(0, 255)), 1'($urandom));

    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          run_chk("exh4", 4, 16'(x), 16'(y), 1'(s));

    for (int i = 0; i < 1500; i++)
      run_chk("rnd16", 16, 16'($urandom), 16'($urandom), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
